// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage of the five-stage RV32I pipeline.
//               Owns the program counter, issues in-order word fetches over a
//               valid/ready request / valid-only response handshake, buffers
//               returned words and drives the IF/ID pipeline register.
//               Redirects from EX restart fetch and discard in-flight words.
//
// Parameters  : RESET_PC         first fetch address after reset
//               MAX_OUTSTANDING  accepted-but-unconsumed fetch limit (1..4)
//
// Ports       : clk              pipeline clock, rising edge
//               rst_n            asynchronous active-low reset
//               imem_req_valid   o  fetch request valid
//               imem_req_ready   i  memory accepts the request this cycle
//               imem_req_addr    o  word-aligned fetch address
//               imem_rsp_valid   i  response word valid (in order)
//               imem_rsp_data    i  returned instruction word
//               redirect_valid   i  taken branch/jump resolved in EX
//               redirect_pc      i  redirect target (bits [1:0] ignored)
//               stall            i  hold IF/ID, stop consuming the buffer
//               flush            i  load a NOP bubble into IF/ID
//               if_id_out        o  IF/ID pipeline register {pc, instr}
//
// Options     : IF_FETCH_BYPASS_EN  when defined, a response arriving while
//               the buffer is empty and the pipe is advancing is written
//               straight into IF/ID instead of taking a trip through the
//               buffer (saves one cycle of fetch latency).
//
// Revision    : 1.0  initial release
// ============================================================================

package if_stage_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    // ADDI x0,x0,0 at pc 0 is the canonical pipeline bubble.
    localparam if_id_t c_BUBBLE = '{pc: 32'h0000_0000, instr: 32'h0000_0013};

endpackage : if_stage_pkg

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,

    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    input  logic        stall,
    input  logic        flush,

    output if_id_t      if_id_out
);

    // ------------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------------
    localparam int c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);

    typedef logic [c_ptr_w-1:0] ptr_t;
    typedef logic [c_cnt_w-1:0] cnt_t;

    localparam ptr_t               c_last_ptr = ptr_t'(MAX_OUTSTANDING - 1);
    localparam logic [c_cnt_w:0]   c_max_sum  = (c_cnt_w + 1)'(MAX_OUTSTANDING);
    localparam logic [31:0]        c_word_msk = 32'hFFFF_FFFC;

    // Circular-buffer pointer increment that also works for non-power-of-two
    // depths.
    function automatic ptr_t f_ptr_inc(input ptr_t p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0] r_pc;
    cnt_t        r_inflight;
    cnt_t        r_drop;
    if_id_t      r_if_id;

    // Request-side PC queue: one entry per in-flight request, so its
    // occupancy is r_inflight. Its head is the PC belonging to the next
    // response, whether that response is kept or dropped.
    logic [31:0] r_pcq_mem [MAX_OUTSTANDING];
    ptr_t        r_pcq_wr;
    ptr_t        r_pcq_rd;

    // Response buffer holding {pc, instr} words waiting for decode.
    if_id_t      r_fifo_mem [MAX_OUTSTANDING];
    ptr_t        r_fifo_wr;
    ptr_t        r_fifo_rd;
    cnt_t        r_fifo_cnt;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [c_cnt_w:0] w_credit_sum;
    logic             w_accept;
    logic             w_rsp;
    logic             w_rsp_keep;
    logic             w_fifo_empty;
    logic             w_advance;
    logic             w_pop;
    logic             w_bypass;
    logic             w_push;
    if_id_t           w_rsp_entry;

    // Every accepted fetch holds one credit until its word leaves the buffer
    // (or is dropped), so the buffer can never overflow.
    assign w_credit_sum   = {1'b0, r_inflight} + {1'b0, r_fifo_cnt};
    assign imem_req_valid = (w_credit_sum < c_max_sum) && !redirect_valid;
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // A response with nothing in flight is a memory protocol violation; it is
    // ignored so the counters cannot underflow.
    assign w_rsp          = imem_rsp_valid && (r_inflight != '0);

    // Words belonging to a squashed fetch stream are discarded, including one
    // that lands in the same cycle as the redirect itself.
    assign w_rsp_keep     = w_rsp && !redirect_valid && (r_drop == '0);
    assign w_rsp_entry    = '{pc: r_pcq_mem[r_pcq_rd], instr: imem_rsp_data};

    assign w_fifo_empty   = (r_fifo_cnt == '0);
    assign w_advance      = !redirect_valid && !flush && !stall;
    assign w_pop          = w_advance && !w_fifo_empty;

`ifdef IF_FETCH_BYPASS_EN
    assign w_bypass       = w_advance && w_fifo_empty && w_rsp_keep;
`else
    assign w_bypass       = 1'b0;
`endif

    assign w_push         = w_rsp_keep && !w_bypass;

    // ------------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC & c_word_msk;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc & c_word_msk;
        end else if (w_accept) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // ------------------------------------------------------------------------
    // In-flight and drop counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_rsp})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // r_drop always counts a subset of the in-flight requests, so after a
    // redirect every request still outstanding (less one answered this
    // cycle) belongs to the dead stream and must be discarded. No request is
    // accepted during a redirect cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (redirect_valid) begin
            r_drop <= w_rsp ? (r_inflight - 1'b1) : r_inflight;
        end else if (w_rsp && (r_drop != '0)) begin
            r_drop <= r_drop - 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Request-side PC queue
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
        end else begin
            if (w_accept) begin
                r_pcq_wr <= f_ptr_inc(r_pcq_wr);
            end
            if (w_rsp) begin
                r_pcq_rd <= f_ptr_inc(r_pcq_rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pcq_mem[r_pcq_wr] <= r_pc;
        end
    end

    // ------------------------------------------------------------------------
    // Response buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_wr  <= '0;
            r_fifo_rd  <= '0;
            r_fifo_cnt <= '0;
        end else if (redirect_valid) begin
            r_fifo_wr  <= '0;
            r_fifo_rd  <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo_wr <= f_ptr_inc(r_fifo_wr);
            end
            if (w_pop) begin
                r_fifo_rd <= f_ptr_inc(r_fifo_rd);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // w_push is already low during a redirect, so storage needs no clear.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_fifo_wr] <= w_rsp_entry;
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID register: redirect > flush > stall > advance
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id <= c_BUBBLE;
        end else if (redirect_valid || flush) begin
            r_if_id <= c_BUBBLE;
        end else if (stall) begin
            r_if_id <= r_if_id;
        end else if (w_pop) begin
            r_if_id <= r_fifo_mem[r_fifo_rd];
        end else if (w_bypass) begin
            r_if_id <= w_rsp_entry;
        end else begin
            r_if_id <= c_BUBBLE;
        end
    end

    assign if_id_out = r_if_id;

endmodule : if_stage

`default_nettype wire
